// File: rtl/kanade_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kanade_mem_pkg
// Purpose  : Shared definitions for the memory port arbiter: access-mode
//            encodings, arbiter FSM state encoding, byte-enable lane masks
//            and small helpers for mode decoding and alignment checks.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package kanade_mem_pkg;

  // Access modes carried on ch_mode. Encodings above MEM_MODE_WORD are
  // undefined and behave as word accesses.
  localparam logic [2:0] MEM_MODE_BYTE       = 3'd0;
  localparam logic [2:0] MEM_MODE_BYTE_SIGN  = 3'd1;
  localparam logic [2:0] MEM_MODE_HWORD      = 3'd2;
  localparam logic [2:0] MEM_MODE_HWORD_SIGN = 3'd3;
  localparam logic [2:0] MEM_MODE_WORD       = 3'd4;

  // Arbiter FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Big-endian lane masks for offset 0; shifted right by the byte offset.
  localparam logic [3:0] C_BE_BYTE  = 4'b1000;
  localparam logic [3:0] C_BE_HWORD = 4'b1100;
  localparam logic [3:0] C_BE_WORD  = 4'b1111;

  // Collapse undefined mode encodings onto word.
  function automatic logic [2:0] mem_mode_norm(input logic [2:0] mode);
    return (mode > MEM_MODE_WORD) ? MEM_MODE_WORD : mode;
  endfunction

  // True when the low address bits do not match the access size.
  function automatic logic mem_misaligned(input logic [2:0] mode,
                                          input logic [1:0] addr_lo);
    logic [2:0] m;
    m = mem_mode_norm(mode);
    if (m == MEM_MODE_HWORD || m == MEM_MODE_HWORD_SIGN) begin
      return addr_lo[0];
    end
    if (m == MEM_MODE_WORD) begin
      return (addr_lo != 2'b00);
    end
    return 1'b0;
  endfunction

endpackage : kanade_mem_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Combinational big-endian byte-lane steering. With STORE=1 the
//            right-aligned store data is moved into its addressed lane and
//            the matching byte enables are produced. With STORE=0 the
//            addressed lane of a RAM word is right-aligned and sign- or
//            zero-extended according to the mode; byte enables read 4'b1111.
// Ports    : mode_i    [2:0]  access mode (MEM_MODE_*)
//            addr_lo_i [1:0]  byte offset within the word
//            data_i    [31:0] store data (STORE=1) or raw RAM word (STORE=0)
//            data_o    [31:0] lane-steered store data or extended load data
//            byteen_o  [3:0]  byte enables, bit 3 = byte offset 0
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import kanade_mem_pkg::*;
#(
  parameter bit STORE = 1'b1
) (
  input  logic [2:0]  mode_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [3:0]  byteen_o
);

  if (STORE) begin : g_store
    always_comb begin
      data_o   = data_i;
      byteen_o = C_BE_WORD;
      case (mem_mode_norm(mode_i))
        MEM_MODE_BYTE, MEM_MODE_BYTE_SIGN: begin
          byteen_o = C_BE_BYTE >> addr_lo_i;
          case (addr_lo_i)
            2'd0:    data_o = {data_i[7:0], 24'h000000};
            2'd1:    data_o = {8'h00, data_i[7:0], 16'h0000};
            2'd2:    data_o = {16'h0000, data_i[7:0], 8'h00};
            default: data_o = {24'h000000, data_i[7:0]};
          endcase
        end
        MEM_MODE_HWORD, MEM_MODE_HWORD_SIGN: begin
          // Only a[1] selects the half; a[0] is ignored here.
          if (addr_lo_i[1]) begin
            byteen_o = C_BE_HWORD >> 2;
            data_o   = {16'h0000, data_i[15:0]};
          end else begin
            byteen_o = C_BE_HWORD;
            data_o   = {data_i[15:0], 16'h0000};
          end
        end
        default: begin
          data_o   = data_i;
          byteen_o = C_BE_WORD;
        end
      endcase
    end
  end else begin : g_load
    logic [7:0]  w_byte;
    logic [15:0] w_hword;

    always_comb begin
      case (addr_lo_i)
        2'd0:    w_byte = data_i[31:24];
        2'd1:    w_byte = data_i[23:16];
        2'd2:    w_byte = data_i[15:8];
        default: w_byte = data_i[7:0];
      endcase
      w_hword  = addr_lo_i[1] ? data_i[15:0] : data_i[31:16];
      byteen_o = C_BE_WORD;
      data_o   = data_i;
      case (mem_mode_norm(mode_i))
        MEM_MODE_BYTE:       data_o = {24'h000000, w_byte};
        MEM_MODE_BYTE_SIGN:  data_o = {{24{w_byte[7]}}, w_byte};
        MEM_MODE_HWORD:      data_o = {16'h0000, w_hword};
        MEM_MODE_HWORD_SIGN: data_o = {{16{w_hword[15]}}, w_hword};
        default:             data_o = data_i;
      endcase
    end
  end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter granting NCH requesters access to a single
//            RAM port with RD_LAT cycles of read latency. One transaction is
//            outstanding at a time (IDLE -> ISSUE -> WAIT -> RESP). Stores are
//            lane-steered big-endian; loads are extracted and extended.
// Config   : MEM_ARB_MISALIGN_CHECK_EN - when defined, misaligned accesses
//            are granted but skip the RAM and complete at T+1 with
//            err_misalign. When undefined, err_misalign is 0 and low address
//            bits below the access size are ignored.
// Ports    : clk, reset            clock, synchronous active-high reset
//            ch_req/ch_we [NCH]    per-channel request / store select
//            ch_addr  [NCH*32]     per-channel byte address
//            ch_mode  [NCH*3]      per-channel access mode (MEM_MODE_*)
//            ch_wdata [NCH*32]     per-channel right-aligned store data
//            ch_gnt/ch_rvalid[NCH] one-hot grant / completion pulses
//            ch_rdata [32]         shared load result
//            err_misalign          misalignment error pulse
//            ram_addr/wren/byteen/wdata, ram_q   RAM port
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import kanade_mem_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*32-1:0] ch_addr,
  input  logic [NCH*3-1:0]  ch_mode,
  input  logic [NCH*32-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_gnt,
  output logic [NCH-1:0]    ch_rvalid,
  output logic [31:0]       ch_rdata,
  output logic              err_misalign,
  output logic [29:0]       ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_q
);

  localparam int CW = $clog2(NCH);
  localparam int IW = CW + 1;  // room for last_gnt + NCH before wrap
  localparam logic [CW-1:0] C_LAST_RST = CW'(NCH - 1);
  localparam logic [2:0]    C_WAIT_LAST = 3'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] last_gnt_q, last_gnt_d;
  logic [CW-1:0] sel_q, sel_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    mode_q, mode_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    wait_cnt_q, wait_cnt_d;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
  logic          misalign_q, misalign_d;
`endif

  logic          w_gnt_vld;
  logic [CW-1:0] w_gnt_idx;
  logic [IW-1:0] w_rr_idx;
  logic [31:0]   w_st_wdata;
  logic [3:0]    w_st_byteen;
  logic [31:0]   w_ld_rdata;
  logic [3:0]    w_ld_byteen;

  // Round-robin pick: scan from last_gnt+1 upward, wrapping modulo NCH.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_rr_idx  = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_rr_idx = IW'(last_gnt_q) + IW'(k);
      if (w_rr_idx >= IW'(NCH)) begin
        w_rr_idx = w_rr_idx - IW'(NCH);
      end
      if (!w_gnt_vld && ch_req[w_rr_idx[CW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_rr_idx[CW-1:0];
      end
    end
  end

  mem_lane_align #(.STORE(1'b1)) u_store_align (
    .mode_i    (mode_q),
    .addr_lo_i (addr_q[1:0]),
    .data_i    (wdata_q),
    .data_o    (w_st_wdata),
    .byteen_o  (w_st_byteen)
  );

  mem_lane_align #(.STORE(1'b0)) u_load_align (
    .mode_i    (mode_q),
    .addr_lo_i (addr_q[1:0]),
    .data_i    (ram_q),
    .data_o    (w_ld_rdata),
    .byteen_o  (w_ld_byteen)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= C_LAST_RST;
      sel_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      mode_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      mode_q     <= mode_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Next-state logic. Grants happen only in IDLE, so a channel with a
  // transaction in flight can never be granted again until it completes.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    sel_d      = sel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          last_gnt_d = w_gnt_idx;
          sel_d      = w_gnt_idx;
          we_d       = ch_we[w_gnt_idx];
          addr_d     = ch_addr[w_gnt_idx*32 +: 32];
          mode_d     = ch_mode[w_gnt_idx*3 +: 3];
          wdata_d    = ch_wdata[w_gnt_idx*32 +: 32];
          wait_cnt_d = '0;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
          misalign_d = mem_misaligned(ch_mode[w_gnt_idx*3 +: 3],
                                      ch_addr[w_gnt_idx*32 +: 2]);
          // Misaligned accesses bypass the RAM and respond next cycle.
          state_d    = misalign_d ? ST_RESP : ST_ISSUE;
`else
          state_d    = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: state_d = (RD_LAT == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt_q == C_WAIT_LAST) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. Everything is forced low while reset is high, which also
  // suppresses a store whose ISSUE cycle coincides with reset.
  always_comb begin
    ch_gnt       = '0;
    ch_rvalid    = '0;
    ch_rdata     = '0;
    err_misalign = 1'b0;
    ram_addr     = '0;
    ram_wren     = 1'b0;
    ram_byteen   = '0;
    ram_wdata    = '0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            ch_gnt[w_gnt_idx] = 1'b1;
          end
        end
        ST_ISSUE: begin
          ram_addr   = addr_q[31:2];
          ram_wren   = we_q;
          ram_byteen = we_q ? w_st_byteen : w_ld_byteen;
          ram_wdata  = we_q ? w_st_wdata : 32'h0;
        end
        ST_RESP: begin
          ch_rvalid[sel_q] = 1'b1;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
          if (misalign_q) begin
            err_misalign = 1'b1;
          end else begin
            ch_rdata = w_ld_rdata;
          end
`else
          ch_rdata = w_ld_rdata;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule : mem_port_arbiter
`default_nettype wire
